// File: rtl/cache_fill_ctrl_if.sv
// CPU, cache and backing-memory signal bundle for the cache fill controller.
interface cache_fill_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LINE_WIDTH = 32
);
  // CPU request / response
  logic                  cpu_valid;
  logic                  cpu_ready;
  logic                  cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [LINE_WIDTH-1:0] cpu_wdata;
  logic                  rsp_valid;
  logic [LINE_WIDTH-1:0] rsp_data;

  // Line cache drive / observe
  logic                  cache_read;
  logic                  cache_write;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic [LINE_WIDTH-1:0] cache_val;
  logic                  cache_hit;
  logic [LINE_WIDTH-1:0] cache_out_val;

  // Backing memory req/ack
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [LINE_WIDTH-1:0] mem_rdata;

  // Controller side
  modport master (
    input  cpu_valid, cpu_write, cpu_addr, cpu_wdata,
    input  cache_hit, cache_out_val,
    input  mem_ack, mem_rdata,
    output cpu_ready, rsp_valid, rsp_data,
    output cache_read, cache_write, cache_addr, cache_val,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  // CPU / cache / memory environment side
  modport slave (
    output cpu_valid, cpu_write, cpu_addr, cpu_wdata,
    output cache_hit, cache_out_val,
    output mem_ack, mem_rdata,
    input  cpu_ready, rsp_valid, rsp_data,
    input  cache_read, cache_write, cache_addr, cache_val,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Initiator-side controller for a K-way fully-associative line cache:
// CPU lookup, miss fetch from memory, write-through with allocate, cache fill.
module cache_fill_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LINE_WIDTH = 32,
  parameter int unsigned K          = 2,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  cache_fill_ctrl_if.master      bus,
  output logic                   fill_err,
  output logic [STAT_WIDTH-1:0]  hit_cnt,
  output logic [STAT_WIDTH-1:0]  miss_cnt
);

  // CLOCK eviction may take 2K+1 edges; give up at FILL cycle 2K+3.
  localparam int unsigned FILL_LIMIT = 2 * K + 3;
  localparam int unsigned FCNT_W     = $clog2(FILL_LIMIT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_MEM_RD = 3'd3;
  localparam logic [2:0] S_MEM_WR = 3'd4;
  localparam logic [2:0] S_FILL   = 3'd5;
  localparam logic [2:0] S_RESP   = 3'd6;

  logic [2:0]            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [LINE_WIDTH-1:0] wdata_q,    wdata_d;
  logic [LINE_WIDTH-1:0] fill_q,     fill_d;
  logic [LINE_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [FCNT_W-1:0]     fcnt_q,     fcnt_d;
  logic                  fill_err_q, fill_err_d;
  logic [STAT_WIDTH-1:0] hit_cnt_q,  hit_cnt_d;
  logic [STAT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  logic cpu_ready_q;
  logic rsp_valid_q;
  logic cache_read_q;
  logic cache_write_q;
  logic mem_req_q;
  logic mem_we_q;

  // Next-state, datapath latching and saturating statistics
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fill_d     = fill_q;
    rsp_data_d = rsp_data_q;
    fcnt_d     = fcnt_q;
    fill_err_d = fill_err_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cpu_valid) begin
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          state_d = bus.cpu_write ? S_MEM_WR : S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        state_d = S_CHECK;
      end

      S_CHECK: begin
        // cache_hit was registered by the cache on the LOOKUP edge
        if (bus.cache_hit) begin
          rsp_data_d = bus.cache_out_val;
          if (hit_cnt_q != {STAT_WIDTH{1'b1}}) begin
            hit_cnt_d = hit_cnt_q + STAT_WIDTH'(1);
          end
          state_d = S_RESP;
        end else begin
          if (miss_cnt_q != {STAT_WIDTH{1'b1}}) begin
            miss_cnt_d = miss_cnt_q + STAT_WIDTH'(1);
          end
          state_d = S_MEM_RD;
        end
      end

      S_MEM_RD: begin
        if (bus.mem_ack) begin
          fill_d  = bus.mem_rdata;
          fcnt_d  = '0;
          state_d = S_FILL;
        end
      end

      S_MEM_WR: begin
        if (bus.mem_ack) begin
          fill_d  = wdata_q;
          fcnt_d  = '0;
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        // fcnt_q == 0 is the first FILL cycle, whose cache_hit is stale
        fcnt_d = fcnt_q + FCNT_W'(1);
        if ((fcnt_q != '0) && bus.cache_hit) begin
          rsp_data_d = fill_q;
          state_d    = S_RESP;
        end else if (fcnt_q == FCNT_W'(FILL_LIMIT - 1)) begin
          fill_err_d = 1'b1;
          rsp_data_d = fill_q;
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and Moore outputs registered from the next state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      fill_q        <= '0;
      rsp_data_q    <= '0;
      fcnt_q        <= '0;
      fill_err_q    <= 1'b0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      cpu_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      cache_read_q  <= 1'b0;
      cache_write_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      fill_q        <= fill_d;
      rsp_data_q    <= rsp_data_d;
      fcnt_q        <= fcnt_d;
      fill_err_q    <= fill_err_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      cpu_ready_q   <= (state_d == S_IDLE);
      rsp_valid_q   <= (state_d == S_RESP);
      cache_read_q  <= (state_d == S_LOOKUP);
      cache_write_q <= (state_d == S_FILL);
      mem_req_q     <= (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
      mem_we_q      <= (state_d == S_MEM_WR);
    end
  end

  // Output wiring
  assign bus.cpu_ready   = cpu_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.cache_read  = cache_read_q;
  assign bus.cache_write = cache_write_q;
  assign bus.cache_addr  = addr_q;
  assign bus.cache_val   = fill_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign fill_err        = fill_err_q;
  assign hit_cnt         = hit_cnt_q;
  assign miss_cnt        = miss_cnt_q;

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Initiator-side controller for the K-way fully-associative line cache; drives its read, write, in_addr and in_val inputs and consumes its hit and out_val outputs.
- Accepts one CPU request at a time through a valid/ready handshake and looks the address up in the cache.
- On a read miss, fetches the line from backing memory over a req/ack handshake, fills the cache, then responds.
- Writes are write-through with write-allocate.

Parameters:
- ADDR_WIDTH, 8, address width; must match the cache.
- LINE_WIDTH, 32, line/data width; must match the cache.
- K, 2, cache associativity; used only to size the fill timeout.
- STAT_WIDTH, 16, width of the saturating hit and miss counters.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- cpu_valid  in  1  CPU request valid.
- cpu_ready  out  1  controller is idle and accepts a request.
- cpu_write  in  1  1 = write request, 0 = read request.
- cpu_addr  in  ADDR_WIDTH  request address.
- cpu_wdata  in  LINE_WIDTH  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  LINE_WIDTH  read data, or echoed write data.
- cache_read  out  1  drives cache read.
- cache_write  out  1  drives cache write.
- cache_addr  out  ADDR_WIDTH  drives cache in_addr.
- cache_val  out  LINE_WIDTH  drives cache in_val.
- cache_hit  in  1  cache hit output.
- cache_out_val  in  LINE_WIDTH  cache out_val.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  LINE_WIDTH  memory write data.
- mem_ack  in  1  one-cycle memory completion.
- mem_rdata  in  LINE_WIDTH  read data, valid with mem_ack.
- fill_err  out  1  sticky flag: cache write timed out.
- hit_cnt  out  STAT_WIDTH  saturating count of read hits.
- miss_cnt  out  STAT_WIDTH  saturating count of read misses.

Behaviour:
- Clock and reset: one clock, `clock`; reset `reset` is asynchronous and active-high.
- Reset values: state=IDLE, cpu_ready=1, all other outputs 0, counters 0, fill_err=0.
- Reset mid-operation: abandons any transaction immediately; mem_req and cache_write drop in the same cycle reset asserts.

State machine (Moore outputs):
- IDLE: cpu_ready=1. On cpu_valid, latch addr, wdata and write into internal registers; cache_addr and mem_addr come from the latched addr.
  - Read → LOOKUP.
  - Write → MEM_WR.
- LOOKUP: cache_read=1 for exactly one cycle → CHECK.
- CHECK: sample cache_hit (registered by the cache on the LOOKUP edge).
  - 1 → latch cache_out_val into rsp_data, increment hit_cnt → RESP.
  - 0 → increment miss_cnt → MEM_RD.
- MEM_RD: mem_req=1, mem_we=0 until mem_ack. On ack, latch mem_rdata into the fill/response register → FILL.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata=latched wdata until mem_ack; fill register = wdata → FILL.
- FILL: cache_write=1, cache_val = fill register.
  - cache_hit is ignored in the first FILL cycle, because it is stale from a prior operation.
  - From the second FILL cycle on, cache_hit=1 → rsp_data = fill register → RESP.
  - CLOCK eviction can need up to 2K+1 edges.
  - If cache_hit has not been seen by FILL cycle 2K+3: set fill_err, → RESP.
- RESP: rsp_valid=1 for one cycle → IDLE.

Latency:
- Read hit: 4 cycles from acceptance to rsp_valid (IDLE→LOOKUP→CHECK→RESP).
- Read miss: 4 + memory latency + fill cycles.

Boundary conditions:
- cpu_ready is 0 outside IDLE; cpu_valid is ignored there and CPU inputs may change freely.
- mem_ack outside MEM_RD or MEM_WR is ignored.
- mem_ack in the same cycle mem_req first rises is legal and completes the request.
- Counters saturate at all-ones; they do not wrap.
- fill_err clears only on reset.
- cache_read and cache_write are never asserted together.

Test Plan:
- Reset, then read addr 0x10 on an empty cache → miss_cnt=1, mem_req (we=0, addr 0x10); memory acks 0xDEADBEEF after 3 cycles → FILL, then rsp_valid with rsp_data=0xDEADBEEF.
- Repeat read of 0x10 → rsp_valid exactly 4 cycles after acceptance, rsp_data=0xDEADBEEF, hit_cnt=1, no mem_req.
- Write 0x20 = 0x12345678 → mem_req with we=1, mem_wdata=0x12345678; then cache fill; rsp_data=0x12345678. Subsequent read of 0x20 hits with 0x12345678.
- K=2: fill 0x10 and 0x20, then read 0x30 → CLOCK eviction completes, rsp arrives, fill_err=0. Cache write held until the second-or-later-cycle hit.
- Cache model that never asserts hit during FILL → fill_err=1 after cycle 2K+3 of FILL, rsp_valid still pulses, controller returns to IDLE.
- Assert reset while mem_req is high → mem_req=0 same cycle, cpu_ready=1, counters 0; late mem_ack after reset is ignored.
